pwm_hum_multi: RTL
==================

PWM_HUM_MULTI -- requirements
Module: pwm_hum_multi

Interface
REQ-001 The block SHALL have parameter NCH, default 2, giving the number of independent PWM channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 10, giving the period counter width in bits.
REQ-003 The block SHALL have parameter PERIOD, default 999, giving the terminal count; the PWM period is PERIOD+1 clk cycles and PERIOD SHALL be < 2^CNT_W.
REQ-004 The block SHALL have parameter STEP, default 50, giving the maximum duty change per period in soft-start mode.
REQ-005 clk  input  1  system clock; all state SHALL update on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  global run enable; 1 = run, 0 = stop and clear.
REQ-008 humidity10  input  4*NCH  per-channel humidity decile; channel i SHALL occupy bits [4i+3:4i].
REQ-009 pwm  output  NCH  registered PWM output; bit i belongs to channel i.
REQ-010 period_end  output  1  registered one-cycle pulse marking counter wrap.
REQ-011 ramping  output  NCH  registered flag per channel; 1 while the applied duty differs from the target duty.

Function
REQ-012 A single shared counter SHALL count 0..PERIOD and wrap to 0 while en=1.
REQ-013 Target duty per channel SHALL be decoded combinationally from humidity10: deciles 0-1 map to floor(PERIOD*20/100), deciles 2-4 to floor(PERIOD*50/100), deciles 5-7 to floor(PERIOD*80/100), and deciles 8-15 to 0.
REQ-014 Duty arithmetic SHALL use at least CNT_W+7 bits, so no intermediate product overflows; with defaults the targets SHALL be 199, 499, 799 and 0.
REQ-015 Each channel SHALL hold an applied duty register, duty_cur, that changes only on the cycle where counter==PERIOD and en=1.
REQ-016 Humidity changes mid-period SHALL NOT affect the current period; only the target value sampled at the wrap cycle SHALL be used.
REQ-017 When counter < duty_cur[i], pwm[i] SHALL be 1 on the next cycle; otherwise pwm[i] SHALL be 0 on the next cycle. Latency is one clk cycle.
REQ-018 duty_cur=0 SHALL give a constant-low output, and all channels SHALL be evaluated against the same counter value.
REQ-019 period_end SHALL be 1 for exactly the one cycle following any cycle with counter==PERIOD and en=1.
REQ-020 ramping[i] SHALL be registered as (duty_cur[i] != target[i]).
REQ-021 When en=0, on the next edge: counter, duty_cur and pwm SHALL go to 0, and period_end SHALL go to 0.
REQ-022 When en rises, counting SHALL start from 0, and soft-start SHALL restart from duty 0.
REQ-023 Simultaneous wrap and en falling: en=0 SHALL take priority and no duty update SHALL occur.

Reset
REQ-024 While rst=0: counter=0, duty_cur=0, pwm=0, period_end=0 and ramping=0, all applied immediately, independent of clk.
REQ-025 Reset asserted mid-period SHALL abort the period; after release, operation SHALL resume as in REQ-022.

Configuration
REQ-026 The macro PWM_HUM_MULTI_RAMP_EN SHALL select the duty update mode.
- Defined: at each wrap, duty_cur moves toward the target by min(STEP, |target-duty_cur|), in either direction, with no overshoot.
- Undefined: at each wrap, duty_cur loads the target directly, and ramping is 1 for at most one period after a target change.

Verification
REQ-027 Reset/idle: rst=0 then release with en=0 -> pwm=0, period_end=0, ramping=0 held for 2000 cycles.
REQ-028 Ramp (RAMP_EN, defaults, NCH=2): en=1, ch0 decile 0 -> ch0 high-cycle count per period = 0, 50, 100, 150, 199, 199, ...; ramping[0] clears after the period in which duty reaches 199.
REQ-029 Direct mode (no RAMP_EN): ch1 decile 6 -> from the second period, 799 high cycles per 1000-cycle period; decile 9 -> 0 high cycles from the next period.
REQ-030 Mid-period change: switch decile 2->5 at counter=300 -> the current period keeps the old duty; the new duty applies only after the next period_end.
REQ-031 Independence and stop: ch0 decile 0 with ch1 decile 8 -> ch1 stays low while ch0 toggles; en=0 at counter=500 -> pwm=0 next cycle; en=1 -> the ramp restarts from 0.

Source files
------------

// File: rtl/pwm_hum_multi.sv
// Multi-channel humidity-driven PWM: one shared period counter, per-channel duty decoded from a humidity decile.
// Define PWM_HUM_MULTI_RAMP_EN for soft-start ramping of the applied duty; otherwise the target loads directly at each wrap.
module pwm_hum_multi #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned PERIOD = 999,
  parameter int unsigned STEP   = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [4*NCH-1:0]   humidity10,
  output logic [NCH-1:0]     pwm,
  output logic               period_end,
  output logic [NCH-1:0]     ramping
);

  localparam int unsigned    DW     = CNT_W + 7;
  localparam logic [DW-1:0]  PER_W  = DW'(PERIOD);
  localparam logic [DW-1:0]  STEP_W = DW'(STEP);
  localparam logic [DW-1:0]  T20    = (PER_W * DW'(20)) / DW'(100);
  localparam logic [DW-1:0]  T50    = (PER_W * DW'(50)) / DW'(100);
  localparam logic [DW-1:0]  T80    = (PER_W * DW'(80)) / DW'(100);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] duty_cur [NCH];
  logic [CNT_W-1:0] target   [NCH];
  logic [CNT_W-1:0] duty_nxt [NCH];
  logic             wrap_c;

  assign wrap_c = (counter == CNT_W'(PERIOD));

  // Decile to target duty decode
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      target[i] = '0;
      case (humidity10[4*i +: 4])
        4'd0, 4'd1:       target[i] = CNT_W'(T20);
        4'd2, 4'd3, 4'd4: target[i] = CNT_W'(T50);
        4'd5, 4'd6, 4'd7: target[i] = CNT_W'(T80);
        default:          target[i] = '0;
      endcase
    end
  end

`ifdef PWM_HUM_MULTI_RAMP_EN
  logic [DW-1:0] delta;

  // Move toward the target by at most STEP, landing exactly on it when closer
  always_comb begin
    delta = '0;
    for (int i = 0; i < NCH; i++) begin
      duty_nxt[i] = target[i];
      if (target[i] >= duty_cur[i]) begin
        delta = DW'(target[i]) - DW'(duty_cur[i]);
        if (delta > STEP_W) duty_nxt[i] = duty_cur[i] + CNT_W'(STEP_W);
      end else begin
        delta = DW'(duty_cur[i]) - DW'(target[i]);
        if (delta > STEP_W) duty_nxt[i] = duty_cur[i] - CNT_W'(STEP_W);
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NCH; i++) duty_nxt[i] = target[i];
  end
`endif

  // Counter, duty latch at wrap, and registered outputs; en=0 clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter    <= '0;
      period_end <= 1'b0;
      pwm        <= '0;
      ramping    <= '0;
      for (int i = 0; i < NCH; i++) duty_cur[i] <= '0;
    end else if (!en) begin
      counter    <= '0;
      period_end <= 1'b0;
      pwm        <= '0;
      ramping    <= '0;
      for (int i = 0; i < NCH; i++) duty_cur[i] <= '0;
    end else begin
      counter    <= wrap_c ? '0 : counter + CNT_W'(1);
      period_end <= wrap_c;
      for (int i = 0; i < NCH; i++) begin
        if (wrap_c) duty_cur[i] <= duty_nxt[i];
        pwm[i]     <= (counter < duty_cur[i]);
        ramping[i] <= (duty_cur[i] != target[i]);
      end
    end
  end

endmodule
